stopwatch_ctrl: RTL and testbench

Control and timekeeping core of the stopwatch. It takes debounced, synchronised start/stop, lap and clear buttons, sequences a run/pause/lap state machine, and gates an internal prescaler that produces the 10 Hz count strobe. It maintains the BCD time count MM:SS.t and drives the display word for the 7-segment driver. It uses a single-clock enable strobe rather than a divided clock.

---
 rtl/stopwatch_ctrl_if.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl_if
//  Purpose  : Button inputs and display/status outputs of the stopwatch
//             control core, bundled for connection between the core and its
//             surroundings.
//  Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
    logic        btn_ss;
    logic        btn_lap;
    logic        btn_clr;
    logic [19:0] disp_bcd;
    logic [1:0]  state;
    logic        running;
    logic        tick_10hz;
    logic        overflow;

    // Button source / display consumer side
    modport master (
        output btn_ss, btn_lap, btn_clr,
        input  disp_bcd, state, running, tick_10hz, overflow
    );

    // Stopwatch core side
    modport slave (
        input  btn_ss, btn_lap, btn_clr,
        output disp_bcd, state, running, tick_10hz, overflow
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Stopwatch control and timekeeping core. Edge-detects the
//             start/stop, lap and clear buttons, sequences IDLE/RUN/PAUSE/LAP,
//             gates a prescaler producing a 10 Hz count strobe and keeps the
//             BCD time MM:SS.t plus a lap register for the display.
//  Options  : SW_WRAP_EN - when defined, 59:59.9 wraps to 00:00.0 with a
//             one-cycle overflow pulse; otherwise the count saturates, the
//             FSM drops to PAUSE and overflow is sticky until clear.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV = 10000000   // clk cycles per tenth; must be >= 2
) (
    input  wire             clk,
    input  wire             reset_n,
    stopwatch_ctrl_if.slave sw
);

    localparam int                    c_PRESC_W   = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0]  c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [19:0]           c_TIME_TERM = 20'h59599;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_running;
    logic                   r_ovf;
    logic [19:0]            r_time;
    logic [19:0]            r_lap;
    logic [19:0]            r_disp;
    logic [c_PRESC_W-1:0]   r_presc;
    logic                   r_ss_q;
    logic                   r_lap_q;
    logic                   r_clr_q;

    logic                   w_clr_ev;
    logic                   w_ss_go;
    logic                   w_lap_go;
    logic                   w_tick;
    logic                   w_wrap;
    logic                   w_sat;
    logic                   w_ss_lock;
    logic [19:0]            w_time_inc;
    logic [19:0]            w_time_nx;

    // Button history for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ss_q  <= 1'b0;
            r_lap_q <= 1'b0;
            r_clr_q <= 1'b0;
        end else begin
            r_ss_q  <= sw.btn_ss;
            r_lap_q <= sw.btn_lap;
            r_clr_q <= sw.btn_clr;
        end
    end

    // Prioritised events (clr > ss > lap), strobe and next BCD time value
    always_comb begin
        w_clr_ev   = sw.btn_clr & ~r_clr_q;
        w_ss_go    = sw.btn_ss  & ~r_ss_q  & ~w_clr_ev;
        w_lap_go   = sw.btn_lap & ~r_lap_q & ~w_clr_ev & ~(sw.btn_ss & ~r_ss_q);
        w_tick     = r_running && (r_presc == c_PRESC_MAX);
        w_wrap     = w_tick && (r_time == c_TIME_TERM);

        // Ripple BCD increment: each digit rolls over into the next
        w_time_inc = r_time;
        if (r_time[3:0] != 4'd9) begin
            w_time_inc[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_time_inc[3:0] = 4'd0;
            if (r_time[7:4] != 4'd9) begin
                w_time_inc[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_time_inc[7:4] = 4'd0;
                if (r_time[11:8] != 4'd5) begin
                    w_time_inc[11:8] = r_time[11:8] + 4'd1;
                end else begin
                    w_time_inc[11:8] = 4'd0;
                    if (r_time[15:12] != 4'd9) begin
                        w_time_inc[15:12] = r_time[15:12] + 4'd1;
                    end else begin
                        w_time_inc[15:12] = 4'd0;
                        if (r_time[19:16] != 4'd5) begin
                            w_time_inc[19:16] = r_time[19:16] + 4'd1;
                        end else begin
                            w_time_inc[19:16] = 4'd0;
                        end
                    end
                end
            end
        end

`ifdef SW_WRAP_EN
        w_sat     = 1'b0;
        w_ss_lock = 1'b0;
        w_time_nx = !w_tick ? r_time : (w_wrap ? 20'h00000 : w_time_inc);
`else
        w_sat     = w_wrap;
        w_ss_lock = r_ovf;
        w_time_nx = (!w_tick || w_wrap) ? r_time : w_time_inc;
`endif
    end

    // Control FSM with time, lap, prescaler and display registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
            r_time    <= 20'h00000;
            r_lap     <= 20'h00000;
            r_disp    <= 20'h00000;
            r_presc   <= '0;
        end else if (w_clr_ev) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
            r_time    <= 20'h00000;
            r_lap     <= 20'h00000;
            r_disp    <= 20'h00000;
            r_presc   <= '0;
        end else begin
            r_time <= w_time_nx;
            r_disp <= w_time_nx;
            // Prescaler only advances while running, so PAUSE keeps the
            // partial tenth for the resume
            if (r_running) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
`ifdef SW_WRAP_EN
            r_ovf <= w_wrap;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_go) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_sat) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                        r_ovf     <= 1'b1;
                    end else if (w_ss_go) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_lap_go) begin
                        // Capture the pre-increment value of this cycle
                        r_state <= ST_LAP;
                        r_lap   <= r_time;
                        r_disp  <= r_time;
                    end
                end
                ST_LAP: begin
                    if (w_sat) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                        r_ovf     <= 1'b1;
                    end else if (w_ss_go) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_lap_go) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_disp <= r_lap;
                    end
                end
                ST_PAUSE: begin
                    if (w_ss_go && !w_ss_lock) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign sw.disp_bcd  = r_disp;
    assign sw.state     = r_state;
    assign sw.running   = r_running;
    assign sw.tick_10hz = w_tick;
    assign sw.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Directed self-checking bench for stopwatch_ctrl (TICK_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_tick;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance n cycles and count cycles in which the strobe is high
    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (sw_if.tick_10hz === 1'b1) cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        sw_if.btn_ss   = 1'b0;
        sw_if.btn_lap  = 1'b0;
        sw_if.btn_clr  = 1'b0;

        // Reset state
        #12;
        check_val("rst_disp", 32'(sw_if.disp_bcd), 32'h0);
        check_val("rst_state", 32'(sw_if.state), 32'd0);
        check_val("rst_running", 32'(sw_if.running), 32'd0);
        check_val("rst_tick", 32'(sw_if.tick_10hz), 32'd0);
        check_val("rst_ovf", 32'(sw_if.overflow), 32'd0);
        reset_n = 1'b1;
        step(1);
        check_val("idle_state", 32'(sw_if.state), 32'd0);

        // lap ignored in IDLE
        sw_if.btn_lap = 1'b1;
        step(1);
        check_val("idle_lap", 32'(sw_if.state), 32'd0);
        sw_if.btn_lap = 1'b0;

        // Start, held button gives a single event, first tick after 4 cycles
        sw_if.btn_ss = 1'b1;
        step(1);
        check_val("start_state", 32'(sw_if.state), 32'd1);
        check_val("start_running", 32'(sw_if.running), 32'd1);
        step(1);
        check_val("held_ss", 32'(sw_if.state), 32'd1);
        sw_if.btn_ss = 1'b0;
        step(2);
        check_val("first_tick", 32'(sw_if.tick_10hz), 32'd1);
        check_val("pre_tick_disp", 32'(sw_if.disp_bcd), 32'h0);
        step(1);
        check_val("disp_1", 32'(sw_if.disp_bcd), 32'h00001);
        check_val("tick_low", 32'(sw_if.tick_10hz), 32'd0);
        count_ticks(36, n_tick);
        check_val("tick_rate", 32'(n_tick), 32'd9);
        check_val("disp_10", 32'(sw_if.disp_bcd), 32'h00010);

        // Pause in the middle of a tenth and resume
        sw_if.btn_clr = 1'b1;
        step(1);
        check_val("clr_state", 32'(sw_if.state), 32'd0);
        check_val("clr_disp", 32'(sw_if.disp_bcd), 32'h0);
        sw_if.btn_clr = 1'b0;
        sw_if.btn_ss  = 1'b1;
        step(1);
        sw_if.btn_ss  = 1'b0;
        step(28);
        check_val("disp_7", 32'(sw_if.disp_bcd), 32'h00007);
        step(2);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        check_val("pause_state", 32'(sw_if.state), 32'd2);
        check_val("pause_running", 32'(sw_if.running), 32'd0);
        count_ticks(20, n_tick);
        check_val("pause_no_tick", 32'(n_tick), 32'd0);
        check_val("pause_disp", 32'(sw_if.disp_bcd), 32'h00007);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        check_val("resume_state", 32'(sw_if.state), 32'd1);
        check_val("resume_tick", 32'(sw_if.tick_10hz), 32'd1);
        step(1);
        check_val("resume_disp", 32'(sw_if.disp_bcd), 32'h00008);

        // Lap freeze and return to live time
        sw_if.btn_clr = 1'b1;
        step(1);
        sw_if.btn_clr = 1'b0;
        sw_if.btn_ss  = 1'b1;
        step(1);
        sw_if.btn_ss  = 1'b0;
        step(48);
        check_val("disp_12", 32'(sw_if.disp_bcd), 32'h00012);
        sw_if.btn_lap = 1'b1;
        step(1);
        sw_if.btn_lap = 1'b0;
        check_val("lap_state", 32'(sw_if.state), 32'd3);
        check_val("lap_disp", 32'(sw_if.disp_bcd), 32'h00012);
        step(8);
        check_val("lap_frozen", 32'(sw_if.disp_bcd), 32'h00012);
        check_val("lap_running", 32'(sw_if.running), 32'd1);
        sw_if.btn_lap = 1'b1;
        step(1);
        sw_if.btn_lap = 1'b0;
        check_val("lap_back_state", 32'(sw_if.state), 32'd1);
        check_val("lap_back_disp", 32'(sw_if.disp_bcd), 32'h00014);

        // clr wins over ss and lap in the same cycle
        sw_if.btn_clr = 1'b1;
        sw_if.btn_ss  = 1'b1;
        sw_if.btn_lap = 1'b1;
        step(1);
        check_val("prio_state", 32'(sw_if.state), 32'd0);
        check_val("prio_disp", 32'(sw_if.disp_bcd), 32'h0);
        check_val("prio_running", 32'(sw_if.running), 32'd0);
        sw_if.btn_clr = 1'b0;
        sw_if.btn_ss  = 1'b0;
        sw_if.btn_lap = 1'b0;
        step(3);
        check_val("prio_stay", 32'(sw_if.state), 32'd0);

        // Terminal count from a preloaded 59:59.8
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        step(1);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        force dut.r_time = 20'h59598;
        step(1);
        release dut.r_time;
        step(1);
        check_val("preload_disp", 32'(sw_if.disp_bcd), 32'h59598);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        step(1);
        check_val("term_tick_a", 32'(sw_if.tick_10hz), 32'd1);
        step(1);
        check_val("disp_59599", 32'(sw_if.disp_bcd), 32'h59599);
        step(3);
        check_val("term_tick_b", 32'(sw_if.tick_10hz), 32'd1);
        step(1);
`ifdef SW_WRAP_EN
        check_val("wrap_disp", 32'(sw_if.disp_bcd), 32'h00000);
        check_val("wrap_ovf", 32'(sw_if.overflow), 32'd1);
        check_val("wrap_state", 32'(sw_if.state), 32'd1);
        step(1);
        check_val("wrap_ovf_pulse", 32'(sw_if.overflow), 32'd0);
        check_val("wrap_state_run", 32'(sw_if.state), 32'd1);
`else
        check_val("sat_disp", 32'(sw_if.disp_bcd), 32'h59599);
        check_val("sat_state", 32'(sw_if.state), 32'd2);
        check_val("sat_ovf", 32'(sw_if.overflow), 32'd1);
        check_val("sat_running", 32'(sw_if.running), 32'd0);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        check_val("sat_ss_ignored", 32'(sw_if.state), 32'd2);
        step(5);
        check_val("sat_hold_disp", 32'(sw_if.disp_bcd), 32'h59599);
        check_val("sat_ovf_sticky", 32'(sw_if.overflow), 32'd1);
`endif
        sw_if.btn_clr = 1'b1;
        step(1);
        sw_if.btn_clr = 1'b0;
        check_val("term_clr_state", 32'(sw_if.state), 32'd0);
        check_val("term_clr_ovf", 32'(sw_if.overflow), 32'd0);
        check_val("term_clr_disp", 32'(sw_if.disp_bcd), 32'h0);

        // Asynchronous reset mid-run, then restart from zero
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        step(6);
        check_val("pre_arst_disp", 32'(sw_if.disp_bcd), 32'h00001);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_disp", 32'(sw_if.disp_bcd), 32'h0);
        check_val("arst_state", 32'(sw_if.state), 32'd0);
        check_val("arst_running", 32'(sw_if.running), 32'd0);
        check_val("arst_tick", 32'(sw_if.tick_10hz), 32'd0);
        check_val("arst_ovf", 32'(sw_if.overflow), 32'd0);
        #3;
        reset_n = 1'b1;
        step(2);
        check_val("post_arst_state", 32'(sw_if.state), 32'd0);
        sw_if.btn_ss = 1'b1;
        step(1);
        sw_if.btn_ss = 1'b0;
        check_val("restart_state", 32'(sw_if.state), 32'd1);
        step(3);
        check_val("restart_tick", 32'(sw_if.tick_10hz), 32'd1);
        check_val("restart_disp0", 32'(sw_if.disp_bcd), 32'h0);
        step(1);
        check_val("restart_disp1", 32'(sw_if.disp_bcd), 32'h00001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
